// File: rtl/lzrw1_decomp_sequencer.sv
// ---------------------------------------------------------------------------
// lzrw1_decomp_sequencer
//
// Front-end controller for the LZRW1 decompressor core. It parses a
// compressed block made of groups. Each group is a 16-bit control word sent
// low byte first, followed by up to ITEMS_PER_GROUP items. Control bits are
// used LSB first: a 0 bit is a one-byte literal and a 1 bit is a two-byte
// copy. Each item is handed to the core as a single dec_valid pulse.
//
// Ports
//   clock      : rising-edge clock
//   reset      : asynchronous, active-high reset
//   start      : one-cycle pulse; accepted only while idle; latches block_len
//   block_len  : compressed block size in bytes, control words included
//   in_byte    : compressed stream byte
//   in_valid   : in_byte is valid
//   in_ready   : a byte is consumed on a cycle with in_valid & in_ready
//   dec_data   : literal = {8'h00, b0}, copy = {b0, b1}
//   dec_flag   : 1 = copy, 0 = literal
//   dec_valid  : one-cycle pulse per item
//   dec_busy   : core busy; an item is never issued while it is high
//   seq_busy   : high whenever the sequencer is not idle
//   done       : one-cycle pulse at block end
//   err        : sticky truncation flag, cleared by the next accepted start
//
// Optional build macro LZRW1_SEQ_STATS_EN adds lit_count / copy_count:
// saturating counts of issued literals and copies, cleared on reset and on
// every accepted start.
// ---------------------------------------------------------------------------
module lzrw1_decomp_sequencer #(
  parameter int ITEMS_PER_GROUP = 16,
  parameter int LEN_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] block_len,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      dec_data,
  output logic             dec_flag,
  output logic             dec_valid,
  input  logic             dec_busy,
  output logic             seq_busy,
  output logic             done,
  output logic             err
`ifdef LZRW1_SEQ_STATS_EN
  ,
  output logic [LEN_W-1:0] lit_count,
  output logic [LEN_W-1:0] copy_count
`endif
);

  // item_idx must hold the value ITEMS_PER_GROUP, hence the extra bit.
  localparam int IDX_W = $clog2(ITEMS_PER_GROUP) + 1;
  localparam int SEL_W = IDX_W - 1;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(ITEMS_PER_GROUP);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CW_LO   = 3'd1,
    CW_HI   = 3'd2,
    ITEM_B0 = 3'd3,
    ITEM_B1 = 3'd4,
    ISSUE   = 3'd5,
    GUARD   = 3'd6,
    FINISH  = 3'd7
  } state_t;

  state_t                     state_r;
  state_t                     next_state_s;
  logic [LEN_W-1:0]           remaining_r;
  logic [ITEMS_PER_GROUP-1:0] cw_r;
  logic [IDX_W-1:0]           item_idx_r;
  logic [7:0]                 b0_r;
  logic [15:0]                dec_data_r;
  logic                       dec_flag_r;
  logic                       in_ready_r;
  logic                       seq_busy_r;
  logic                       done_r;
  logic                       err_r;

  logic                       start_acc_s;
  logic                       consume_s;
  logic                       cw_lo_ld_s;
  logic                       cw_hi_ld_s;
  logic                       b0_ld_s;
  logic                       lit_ld_s;
  logic                       copy_ld_s;
  logic                       idx_inc_s;
  logic                       err_set_s;
  logic                       issue_s;
  logic                       rem_last_s;
  logic                       cw_bit_s;
  logic [IDX_W-1:0]           idx_next_s;

  // States in which the sequencer pulls bytes from the stream.
  function automatic logic is_fetch(input state_t s);
    return (s == CW_LO) || (s == CW_HI) || (s == ITEM_B0) || (s == ITEM_B1);
  endfunction

  assign rem_last_s = (remaining_r == LEN_ONE);
  assign cw_bit_s   = cw_r[item_idx_r[SEL_W-1:0]];
  assign idx_next_s = item_idx_r + IDX_ONE;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    next_state_s = state_r;
    start_acc_s  = 1'b0;
    consume_s    = 1'b0;
    cw_lo_ld_s   = 1'b0;
    cw_hi_ld_s   = 1'b0;
    b0_ld_s      = 1'b0;
    lit_ld_s     = 1'b0;
    copy_ld_s    = 1'b0;
    idx_inc_s    = 1'b0;
    err_set_s    = 1'b0;
    issue_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          if (block_len == LEN_ZERO) begin
            next_state_s = FINISH;
          end else begin
            next_state_s = CW_LO;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      CW_LO: begin
        if (in_valid) begin
          consume_s  = 1'b1;
          cw_lo_ld_s = 1'b1;
          // Stream ran out between the two control-word bytes.
          if (rem_last_s) begin
            err_set_s    = 1'b1;
            next_state_s = FINISH;
          end else begin
            next_state_s = CW_HI;
          end
        end else begin
          next_state_s = CW_LO;
        end
      end
      CW_HI: begin
        if (in_valid) begin
          consume_s  = 1'b1;
          cw_hi_ld_s = 1'b1;
          // A control word with no items after it is a legal block end.
          if (rem_last_s) begin
            next_state_s = FINISH;
          end else begin
            next_state_s = ITEM_B0;
          end
        end else begin
          next_state_s = CW_HI;
        end
      end
      ITEM_B0: begin
        if (in_valid) begin
          consume_s = 1'b1;
          b0_ld_s   = 1'b1;
          if (!cw_bit_s) begin
            lit_ld_s     = 1'b1;
            next_state_s = ISSUE;
          end else if (rem_last_s) begin
            // Copy with its second byte missing: drop it, flag truncation.
            err_set_s    = 1'b1;
            next_state_s = FINISH;
          end else begin
            next_state_s = ITEM_B1;
          end
        end else begin
          next_state_s = ITEM_B0;
        end
      end
      ITEM_B1: begin
        if (in_valid) begin
          consume_s    = 1'b1;
          copy_ld_s    = 1'b1;
          next_state_s = ISSUE;
        end else begin
          next_state_s = ITEM_B1;
        end
      end
      ISSUE: begin
        if (!dec_busy) begin
          issue_s      = 1'b1;
          next_state_s = GUARD;
        end else begin
          next_state_s = ISSUE;
        end
      end
      GUARD: begin
        // Dead cycle so the core has time to raise busy for this item.
        idx_inc_s = 1'b1;
        if (remaining_r == LEN_ZERO) begin
          next_state_s = FINISH;
        end else if (idx_next_s == IDX_FULL) begin
          next_state_s = CW_LO;
        end else begin
          next_state_s = ITEM_B0;
        end
      end
      FINISH: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Byte counter, control word, item index, captured bytes and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      remaining_r <= LEN_ZERO;
      cw_r        <= {ITEMS_PER_GROUP{1'b0}};
      item_idx_r  <= IDX_ZERO;
      b0_r        <= 8'h00;
      dec_data_r  <= 16'h0000;
      dec_flag_r  <= 1'b0;
      in_ready_r  <= 1'b0;
      seq_busy_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (start_acc_s) begin
        remaining_r <= block_len;
      end else if (consume_s && (remaining_r != LEN_ZERO)) begin
        remaining_r <= remaining_r - LEN_ONE;
      end
      if (cw_lo_ld_s) begin
        cw_r[7:0] <= in_byte;
      end
      if (cw_hi_ld_s) begin
        cw_r[15:8] <= in_byte;
      end
      if (cw_hi_ld_s) begin
        item_idx_r <= IDX_ZERO;
      end else if (idx_inc_s) begin
        item_idx_r <= idx_next_s;
      end
      if (b0_ld_s) begin
        b0_r <= in_byte;
      end
      // Item data is loaded on entry to ISSUE and held until the next item.
      if (lit_ld_s) begin
        dec_data_r <= {8'h00, in_byte};
        dec_flag_r <= 1'b0;
      end else if (copy_ld_s) begin
        dec_data_r <= {b0_r, in_byte};
        dec_flag_r <= 1'b1;
      end
      if (start_acc_s) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end
      // Loaded from the next state so these line up with the current state.
      in_ready_r <= is_fetch(next_state_s);
      seq_busy_r <= (next_state_s != IDLE);
      done_r     <= (state_r == FINISH);
    end
  end

  assign in_ready = in_ready_r;
  assign dec_data = dec_data_r;
  assign dec_flag = dec_flag_r;
  assign seq_busy = seq_busy_r;
  assign done     = done_r;
  assign err      = err_r;
  // The issue must land on the very cycle busy drops, so it is decoded from
  // the state register and the live busy input.
  assign dec_valid = issue_s;

`ifdef LZRW1_SEQ_STATS_EN
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  logic [LEN_W-1:0] lit_count_r;
  logic [LEN_W-1:0] copy_count_r;

  // Saturating per-kind item counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lit_count_r  <= LEN_ZERO;
      copy_count_r <= LEN_ZERO;
    end else if (start_acc_s) begin
      lit_count_r  <= LEN_ZERO;
      copy_count_r <= LEN_ZERO;
    end else if (issue_s) begin
      if (dec_flag_r) begin
        if (copy_count_r != LEN_MAX) begin
          copy_count_r <= copy_count_r + LEN_ONE;
        end
      end else begin
        if (lit_count_r != LEN_MAX) begin
          lit_count_r <= lit_count_r + LEN_ONE;
        end
      end
    end
  end

  assign lit_count  = lit_count_r;
  assign copy_count = copy_count_r;
`endif

endmodule

// File: doc/lzrw1_decomp_sequencer.md
Name: lzrw1_decomp_sequencer

Overview:
- Front-end controller for the LZRW1 decompressor core.
- Consumes a compressed byte stream made of groups: one 16-bit control word, then up to 16 items.
- Splits the stream into literal and copy items and presents each one, with its control bit, to the decompressor.
- Honours the core's busy flag. Signals done/error at end of block.

Parameters:
- ITEMS_PER_GROUP, 16: items per control word; equals control-word width.
- LEN_W, 16: width of the block length and byte counters.

Ports:
- clock  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-high.
- start  in  1: one-cycle pulse; accepted only in IDLE. Latches block_len.
- block_len  in  LEN_W: compressed block size in bytes, control words included.
- in_byte  in  8: compressed stream byte.
- in_valid  in  1: in_byte valid.
- in_ready  out  1: byte consumed on cycle with in_valid & in_ready.
- dec_data  out  16: to core data_in. Literal = {8'h00, b0}; copy = {b0, b1}.
- dec_flag  out  1: to core control_word_in. 1 = copy, 0 = literal.
- dec_valid  out  1: to core data_in_valid; one-cycle pulse per item.
- dec_busy  in  1: from core decompressor_busy.
- seq_busy  out  1: high in any state other than IDLE.
- done  out  1: one-cycle pulse at block end.
- err  out  1: sticky truncation flag; cleared by the next accepted start.

Behaviour:
- Reset values: in_ready=0, dec_valid=0, dec_flag=0, dec_data=0, seq_busy=0, done=0, err=0. FSM enters IDLE. Counters are cleared.
- Reset asserted mid-block aborts immediately. No done pulse is produced. Partially fetched bytes are discarded.
- FSM states: IDLE, CW_LO, CW_HI, ITEM_B0, ITEM_B1, ISSUE, GUARD, FINISH.
- IDLE:
  - On start, latch remaining = block_len.
  - remaining==0 -> FINISH.
  - Otherwise -> CW_LO.
- CW_LO / CW_HI:
  - in_ready=1. Capture the low byte, then the high byte, into cw. Decrement remaining per byte.
  - Set item_idx=0 after CW_HI.
  - remaining==0 after CW_HI -> FINISH (empty group is legal).
  - Byte stream ends (remaining==0) between CW_LO and CW_HI -> set err, go to FINISH.
- ITEM_B0:
  - Control bit is cw[item_idx], LSB first. in_ready=1; capture b0.
  - Bit 0 -> ISSUE.
  - Bit 1 -> ITEM_B1. If remaining==0 after b0, set err and go to FINISH; no partial item is issued.
- ITEM_B1: in_ready=1; capture b1 -> ISSUE.
- ISSUE:
  - Wait while dec_busy=1.
  - On the first cycle with dec_busy=0: drive dec_valid=1 for that single cycle with dec_data/dec_flag stable -> GUARD.
- GUARD:
  - One dead cycle, no issue, so the core can raise busy.
  - Then increment item_idx. Next state is evaluated in order:
    - remaining==0 -> FINISH.
    - item_idx==ITEMS_PER_GROUP -> CW_LO.
    - Otherwise -> ITEM_B0.
- FINISH: pulse done=1 for one cycle -> IDLE.
- Cycle rules:
  - in_ready is deasserted in IDLE, ISSUE, GUARD and FINISH.
  - in_valid=0 stalls the FSM in its fetch state with no side effects.
  - start outside IDLE is ignored.
- Counters:
  - remaining: LEN_W bits, decrements by 1 per consumed byte, never underflows.
  - item_idx: ceil(log2(ITEMS_PER_GROUP))+1 bits.
- Minimum issue interval is 3 cycles for a literal with data present: ITEM_B0, ISSUE, GUARD.
- dec_data/dec_flag hold their last value outside ISSUE.

Optional Feature:
- Macro: LZRW1_SEQ_STATS_EN.
- Defined:
  - Adds outputs lit_count (LEN_W) and copy_count (LEN_W).
  - Each increments on a dec_valid pulse, selected by dec_flag, and saturates at all-ones.
  - Both clear on reset and on an accepted start.
- Undefined: the ports and counters do not exist. No other behavioural change.

Test Plan:
- Empty block: block_len=0, start -> done pulses 2 cycles after start; no in_ready; dec_valid never asserted; err=0.
- All literals: block_len=18, bytes 00 00 then 41..50 (16 bytes), dec_busy=0:
  - 16 dec_valid pulses, dec_flag=0, dec_data=0x0041..0x0050, spaced 3 cycles apart.
  - Then done.
- Mixed group: bytes 02 00 41 F0 12 42:
  - Literal 0x0041, copy 0xF012 with dec_flag=1, literal 0x0042.
  - Then done, err=0.
- Busy backpressure: during the copy issue of the mixed-group stream, hold dec_busy=1 for 7 cycles -> dec_valid asserts exactly on the first cycle with busy=0; no bytes consumed meanwhile.
- Truncation:
  - block_len=3 with bytes 01 00 F0 -> no dec_valid; err=1; done pulses.
  - A following start with block_len=0 -> err clears.
- Reset mid-block: assert reset while in ISSUE -> dec_valid=0, seq_busy=0, done never pulses; a fresh 3-byte literal block afterwards decodes correctly.
